rr_arb_mux: RTL and testbench

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/rr_arb_mux.sv | 69 ++++++
 tb/tb_rr_arb_mux.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// N-channel arbiter feeding a single registered output stage.
// Grant is fixed-priority (mode=0) or round-robin from ptr (mode=1).
module rr_arb_mux #(
  parameter int W  = 32,
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [IW-1:0]  out_sel
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] g;
  logic          grant;
  logic [W-1:0]  g_data;
  logic          load;
  int            idx;

  assign load = !out_valid || out_ready;

  // Scan order starts at ptr in round-robin mode, at 0 in fixed mode.
  // rst_n gates the grant so in_ready stays low throughout reset.
  always_comb begin
    grant  = 1'b0;
    g      = '0;
    g_data = '0;
    idx    = 0;
    if (load && rst_n) begin
      for (int k = 0; k < N; k++) begin
        idx = mode ? ((int'(ptr) + k) % N) : k;
        if (!grant && in_valid[idx]) begin
          grant  = 1'b1;
          g      = IW'(idx);
          g_data = in_data[idx*W +: W];
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (grant) in_ready[g] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_sel   <= g;
      if (mode) ptr <= (g == IW'(N - 1)) ? '0 : g + IW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux (N=4, W=32): reset, fixed priority,
// round-robin order, wrap/skip, back-pressure, drain and mid-run reset.
module tb_rr_arb_mux;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_sel;
  logic [W-1:0]   d [N];

  int passed = 0;
  int total  = 0;

  assign in_data = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  rr_arb_mux #(.W(W), .N(N), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] dat, input int sel);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".out_data"},  out_data, dat);
    check({tag, ".out_sel"},   32'(out_sel), 32'(sel));
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) d[i] = 32'hA0 + 32'(i);

    // Reset state, with requests pending
    #2;
    check_out("reset", 1'b0, 32'h0, 0);
    check("reset.in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed priority: channel 1 always wins over 3
    mode     = 1'b0;
    in_valid = 4'b1010;
    #1 check("fixed.in_ready0", 32'(in_ready), 32'b0010);
    for (int c = 0; c < 3; c++) begin
      step();
      check_out("fixed", 1'b1, 32'hA1, 1);
      check("fixed.in_ready", 32'(in_ready), 32'b0010);
    end

    // Round-robin from ptr=0 (fixed mode must not have moved ptr)
    mode     = 1'b1;
    in_valid = 4'b1111;
    #1 check("rr.in_ready0", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      step();
      check_out("rr", 1'b1, 32'hA0 + 32'(k % 4), k % 4);
      check("rr.in_ready", 32'(in_ready), 32'(1 << ((k + 1) % 4)));
    end

    // ptr is 1; grant 2 to move ptr to 3, then wrap to 0 and on to 1
    in_valid = 4'b0100;
    step();
    check_out("wrap.g2", 1'b1, 32'hA2, 2);
    in_valid = 4'b0011;
    #1 check("wrap.in_ready_a", 32'(in_ready), 32'b0001);
    step();
    check_out("wrap.g0", 1'b1, 32'hA0, 0);
    check("wrap.in_ready_b", 32'(in_ready), 32'b0010);
    step();
    check_out("wrap.g1", 1'b1, 32'hA1, 1);

    // Back-pressure: held word stays put, no ready upstream
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    d[2]      = 32'hC2;
    for (int c = 0; c < 3; c++) begin
      #1 check("bp.in_ready", 32'(in_ready), 32'h0);
      step();
      check_out("bp.hold", 1'b1, 32'hA1, 1);
    end
    out_ready = 1'b1;
    #1 check("bp.in_ready_rel", 32'(in_ready), 32'b0100);
    step();
    check_out("bp.load", 1'b1, 32'hC2, 2);

    // Drain: valid drops, data and sel retained
    in_valid = 4'b0000;
    step();
    check_out("drain", 1'b0, 32'hC2, 2);
    check("drain.in_ready", 32'(in_ready), 32'h0);

    // Reset mid-operation discards the held word and returns ptr to 0
    in_valid = 4'b0001;
    step();
    check_out("pre_rst", 1'b1, 32'hA0, 0);
    in_valid  = 4'b1110;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_out("mid_rst", 1'b0, 32'h0, 0);
    check("mid_rst.in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    #1 check("post_rst.in_ready", 32'(in_ready), 32'b0001);
    step();
    check_out("post_rst", 1'b1, 32'hA0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
